wb_serial_master: RTL

WB_SERIAL_MASTER -- requirements
Module: wb_serial_master

---
 rtl/bexkat_dbg_pkg.sv | 17 +
 rtl/if_wb.sv | 14 +
 rtl/dbg_tx_shift.sv | 55 +++++
 rtl/wb_serial_master.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bexkat_dbg_pkg.sv
// Shared opcodes, response codes and FSM states for the serial-to-Wishbone debug master.
package bexkat_dbg_pkg;

   localparam logic [7:0] OP_READ  = 8'h01;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      BUS,
      RESP
   } state_t;

endpackage

// File: rtl/if_wb.sv
// Minimal 32-bit Wishbone classic bundle.
interface if_wb;
   logic [31:0] adr;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic [3:0]  sel;
   logic        cyc;
   logic        stb;
   logic        we;
   logic        ack;

   modport master (output adr, dat_o, sel, cyc, stb, we, input dat_i, ack);
   modport slave  (input adr, dat_o, sel, cyc, stb, we, output dat_i, ack);
endinterface

// File: rtl/dbg_tx_shift.sv
// Response serializer: 4-byte shift register emitting MSB first over a valid/ready handshake.
module dbg_tx_shift (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load,
   input  logic [31:0] load_word,
   input  logic [1:0]  load_last,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        done
);

   logic [31:0] shift_q, shift_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        valid_q, valid_d;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   // cnt_q holds the number of bytes remaining after the one on tx_data
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      done    = 1'b0;
      if (load) begin
         shift_d = load_word;
         cnt_d   = load_last;
         valid_d = 1'b1;
      end else if (valid_q && tx_ready) begin
         if (cnt_q == 2'd0) begin
            shift_d = '0;
            valid_d = 1'b0;
            done    = 1'b1;
         end else begin
            shift_d = {shift_q[23:0], 8'h00};
            cnt_d   = cnt_q - 2'd1;
         end
      end
   end

   assign tx_data  = shift_q[31:24];
   assign tx_valid = valid_q;

endmodule

// File: rtl/wb_serial_master.sv
// Byte-stream command decoder driving a single Wishbone read or write per command.
module wb_serial_master
   import bexkat_dbg_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter logic [3:0]  SEL_ALL = 4'hF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   if_wb.master        bus,
   output logic        busy
);

   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          is_wr_q, is_wr_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic          cyc_q, cyc_d;
   logic          we_q, we_d;
   logic [3:0]    sel_q, sel_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic          tx_load;
   logic [31:0]   tx_word;
   logic [1:0]    tx_last;
   logic          tx_done;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         is_wr_q <= 1'b0;
         bcnt_q  <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         is_wr_q <= is_wr_d;
         bcnt_q  <= bcnt_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      is_wr_d = is_wr_q;
      bcnt_d  = bcnt_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      sel_d   = sel_q;
      tmo_d   = tmo_q;
      tx_load = 1'b0;
      tx_word = '0;
      tx_last = '0;

      unique case (state_q)
         IDLE: begin
            if (rx_valid) begin
               if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                  is_wr_d = (rx_data == OP_WRITE);
                  bcnt_d  = '0;
                  state_d = ADDR;
               end else begin
                  tx_load = 1'b1;
                  tx_word = {RSP_NAK, 24'h0};
                  state_d = RESP;
               end
            end
         end
         ADDR: begin
            if (rx_valid) begin
               adr_d  = {adr_q[23:0], rx_data};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  if (is_wr_q) begin
                     state_d = WDATA;
                  end else begin
                     state_d = BUS;
                     cyc_d   = 1'b1;
                     we_d    = 1'b0;
                     sel_d   = SEL_ALL;
                     tmo_d   = '0;
                  end
               end
            end
         end
         WDATA: begin
            if (rx_valid) begin
               dat_d  = {dat_q[23:0], rx_data};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  state_d = BUS;
                  cyc_d   = 1'b1;
                  we_d    = 1'b1;
                  sel_d   = SEL_ALL;
                  tmo_d   = '0;
               end
            end
         end
         BUS: begin
            // ack is checked before the timeout so a last-cycle ack still succeeds
            if (bus.ack) begin
               cyc_d   = 1'b0;
               tx_load = 1'b1;
               state_d = RESP;
               if (is_wr_q) begin
                  tx_word = {RSP_ACK, 24'h0};
               end else begin
                  tx_word = bus.dat_i;
                  tx_last = 2'd3;
               end
            end else if (tmo_q == TMO_LAST) begin
               cyc_d   = 1'b0;
               tx_load = 1'b1;
               tx_word = {RSP_NAK, 24'h0};
               state_d = RESP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RESP: begin
            if (tx_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   dbg_tx_shift u_tx (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (tx_load),
      .load_word (tx_word),
      .load_last (tx_last),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .done      (tx_done)
   );

   assign bus.adr   = adr_q;
   assign bus.dat_o = dat_q;
   assign bus.sel   = sel_q;
   assign bus.cyc   = cyc_q;
   assign bus.stb   = cyc_q;
   assign bus.we    = we_q;
   assign busy      = (state_q != IDLE);

endmodule
